// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

    localparam int PRESCALE_8       = 8;
    localparam int PRESCALE_16      = 16;
    localparam int PRESCALE_32      = 32;
    localparam int PRESCALE_DEFAULT = PRESCALE_8;

    localparam logic UART_IDLE = 1'b1;

    // Majority of three samples; a single glitched sample cannot flip the bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Shared by the RX and TX paths; RST_VAL picks the idle level.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// Oversampling front end of the UART receiver: synchronises the line,
// tracks the position inside each bit period and decides every bit with a
// 3-sample majority vote around mid-bit. Frame sequencing lives in the RX FSM.
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  rx_sync
);

    logic                  w_rx_sync;
    logic                  w_en_rise;
    logic [PRESCALE_W-1:0] w_p_decoded;
    logic [PRESCALE_W-1:0] w_p;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_last;
    logic [PRESCALE_W-1:0] w_s0_pt;
    logic [PRESCALE_W-1:0] w_s1_pt;
    logic [PRESCALE_W-1:0] w_s2_pt;
    logic [PRESCALE_W-1:0] w_dec_pt;

    logic                  r_enable_q;
    logic [PRESCALE_W-1:0] r_p;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_s2;
    logic                  r_sampled_bit;
    logic                  r_sample_valid;

    uart_rx_sync #(
        .RST_VAL (UART_IDLE)
    ) u_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (RX_IN),
        .o_q   (w_rx_sync)
    );

    // Only 8, 16 and 32 are supported ratios; anything else falls back to 8.
    always_comb begin
        w_p_decoded = PRESCALE_W'(PRESCALE_DEFAULT);
        if (prescale == PRESCALE_W'(PRESCALE_8) ||
            prescale == PRESCALE_W'(PRESCALE_16) ||
            prescale == PRESCALE_W'(PRESCALE_32)) begin
            w_p_decoded = prescale;
        end
    end

    // The rising edge of enable uses the live prescale so the very first
    // counting cycle already runs with the captured ratio.
    assign w_en_rise = enable & ~r_enable_q;
    assign w_p       = w_en_rise ? w_p_decoded : r_p;
    assign w_half    = w_p >> 1;
    assign w_last    = w_p - PRESCALE_W'(1);
    assign w_s0_pt   = w_half - PRESCALE_W'(1);
    assign w_s1_pt   = w_half;
    assign w_s2_pt   = w_half + PRESCALE_W'(1);
    assign w_dec_pt  = w_half + PRESCALE_W'(2);

    // Capture the effective prescale once per enable window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_enable_q <= 1'b0;
            r_p        <= PRESCALE_W'(PRESCALE_DEFAULT);
        end else begin
            r_enable_q <= enable;
            if (w_en_rise) begin
                r_p <= w_p_decoded;
            end
        end
    end

    // Position within the bit period, wrapping at P-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_cnt <= '0;
        end else if (!enable) begin
            r_edge_cnt <= '0;
        end else if (r_edge_cnt == w_last) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        end
    end

    // Bit index within the frame, saturating at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bit_cnt <= '0;
        end else if (!enable) begin
            r_bit_cnt <= '0;
        end else if (r_edge_cnt == w_last && r_bit_cnt != {BIT_CNT_W{1'b1}}) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    // Three consecutive mid-bit samples; held while disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s0 <= UART_IDLE;
            r_s1 <= UART_IDLE;
            r_s2 <= UART_IDLE;
        end else if (enable) begin
            if (r_edge_cnt == w_s0_pt) r_s0 <= w_rx_sync;
            if (r_edge_cnt == w_s1_pt) r_s1 <= w_rx_sync;
            if (r_edge_cnt == w_s2_pt) r_s2 <= w_rx_sync;
        end
    end

    // One majority decision per bit period, flagged by a single-cycle strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sampled_bit  <= UART_IDLE;
            r_sample_valid <= 1'b0;
        end else if (enable && r_edge_cnt == w_dec_pt) begin
            r_sampled_bit  <= majority3(r_s0, r_s1, r_s2);
            r_sample_valid <= 1'b1;
        end else begin
            r_sample_valid <= 1'b0;
        end
    end

    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;
    assign edge_cnt     = r_edge_cnt;
    assign bit_cnt      = r_bit_cnt;
    assign rx_sync      = w_rx_sync;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Scoreboard bench for uart_rx_bit_sampler: stimulus pushes expected
// decisions, a negedge monitor pops them whenever sample_valid is seen.
module tb_uart_rx_bit_sampler;

    typedef struct {
        logic       bit_v;
        logic [3:0] bcnt;
        logic [5:0] ecnt;
        int         gap;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       enable = 1'b0;
    logic       sampled_bit;
    logic       sample_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       rx_sync;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_bit_sampler #(
        .PRESCALE_W (6),
        .BIT_CNT_W  (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .enable       (enable),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .rx_sync      (rx_sync)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected decision.
    always @(negedge CLK) begin
        if (!RST && sample_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_bit", sampled_bit, mon_e.bit_v);
                chk("pulse_bit_cnt", bit_cnt, mon_e.bcnt);
                chk("pulse_edge_cnt", edge_cnt, mon_e.ecnt);
                if (mon_e.gap != 0) chk("pulse_gap", cyc - last_pulse, mon_e.gap);
            end
            last_pulse = cyc;
        end
    end

    // Drives n bits of p negedges each, starting at the current negedge.
    // Bit b is sampled at negedges b*p + p/2-3 .. p/2-1 (two-flop latency).
    task automatic run_frame(input logic [5:0] psel, input int p,
                             input logic [15:0] bits, input logic [15:0] exp_bits,
                             input int n, input int g_bit, input int g_t,
                             input int g_len, input int chg_at);
        for (int b = 0; b < n; b++) begin
            sb.push_back('{exp_bits[b], 4'(b), 6'(p / 2 + 3), (b == 0) ? 0 : p});
        end
        enable   = 1'b1;
        prescale = psel;
        for (int i = 0; i < n * p; i++) begin
            int b, t;
            b = i / p;
            t = i % p;
            RX_IN = bits[b];
            if (b == g_bit && t >= g_t && t < g_t + g_len) RX_IN = ~bits[b];
            if (i == chg_at) prescale = 6'd16;
            if (t == p - 1) begin
                chk("wrap_edge_cnt", edge_cnt, p - 1);
                chk("wrap_bit_cnt", bit_cnt, b);
            end
            @(negedge CLK);
        end
        enable   = 1'b0;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        repeat (4) @(negedge CLK);
        chk("drain_queue", sb.size(), 0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog timeout (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_sampled_bit", sampled_bit, 1);
        chk("rst_rx_sync", rx_sync, 1);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_edge_cnt", edge_cnt, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Synchroniser latency: two edges
        RX_IN = 1'b0;
        @(negedge CLK);
        chk("sync_lat1", rx_sync, 1);
        @(negedge CLK);
        chk("sync_lat2", rx_sync, 0);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);

        // Clean bits at P=8: 0,1,0,1
        run_frame(6'd8, 8, 16'h000A, 16'h000A, 4, -1, 0, 0, -1);

        // Glitch at P=16: two-cycle 0 over s1,s2 -> 0; one-cycle 0 on s1 -> 1
        run_frame(6'd16, 16, 16'h0001, 16'h0000, 1, 0, 6, 2, -1);
        run_frame(6'd16, 16, 16'h0001, 16'h0001, 1, 0, 6, 1, -1);

        // Full frame at P=32: start, 0xA5 LSB first, stop
        run_frame(6'd32, 32, 16'h034A, 16'h034A, 10, -1, 0, 0, -1);

        // Illegal prescale 12 -> P=8; prescale moved to 16 mid-frame
        run_frame(6'd12, 8, 16'h0016, 16'h0016, 5, -1, 0, 0, 10);

        // Enable drop at edge_cnt=3 of the second bit, P=8
        sb.push_back('{1'b0, 4'd0, 6'd7, 0});
        enable   = 1'b1;
        prescale = 6'd8;
        for (int i = 0; i < 11; i++) begin
            RX_IN = (i < 8) ? 1'b0 : 1'b1;
            @(negedge CLK);
        end
        chk("drop_pre_edge_cnt", edge_cnt, 3);
        enable = 1'b0;
        @(negedge CLK);
        chk("drop_edge_cnt", edge_cnt, 0);
        chk("drop_bit_cnt", bit_cnt, 1'b0);
        chk("drop_sampled_bit", sampled_bit, 0);
        repeat (12) @(negedge CLK);
        chk("drop_hold_bit", sampled_bit, 0);
        chk("drop_queue", sb.size(), 0);

        // Reset mid-frame at edge_cnt=P/2, P=8
        enable   = 1'b1;
        prescale = 6'd8;
        RX_IN    = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rstmid_pre_edge_cnt", edge_cnt, 4);
        RST = 1'b1;
        #1;
        chk("rstmid_sampled_bit", sampled_bit, 1);
        chk("rstmid_rx_sync", rx_sync, 1);
        chk("rstmid_sample_valid", sample_valid, 0);
        chk("rstmid_edge_cnt", edge_cnt, 0);
        chk("rstmid_bit_cnt", bit_cnt, 0);
        repeat (2) @(negedge CLK);
        chk("rstmid_hold_edge_cnt", edge_cnt, 0);
        RST = 1'b0;
        run_frame(6'd8, 8, 16'h0001, 16'h0001, 2, -1, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_bit_sampler.md
# uart_rx_bit_sampler

Oversampling front end of the UART receiver. It synchronises the raw serial line, tracks position within each bit period with an edge counter and a bit counter, and decides each bit by a 3-sample majority vote around mid-bit. It sits directly upstream of the `deserializer`. The RX FSM uses `sample_valid` to pulse `deser_en` and forwards `sampled_bit` unchanged.

## Interface
- `PRESCALE_W`, 6, width of the `prescale` input and of `edge_cnt`.
- `BIT_CNT_W`, 4, width of `bit_cnt`. It must cover start + DATA_WIDTH + parity + stop.
- `CLK`  input  1  system clock (oversampling clock).
- `RST`  input  1  reset. Asynchronous, active-high.
- `RX_IN`  input  1  raw serial line, asynchronous to `CLK`, idle high.
- `prescale`  input  PRESCALE_W  oversampling ratio. Legal values are 8, 16 and 32.
- `enable`  input  1  from the RX FSM. High while a frame is being received.
- `sampled_bit`  output  1  last decided bit value. Held between decisions.
- `sample_valid`  output  1  one-cycle strobe. Marks the cycle in which `sampled_bit` carries a new decision.
- `edge_cnt`  output  PRESCALE_W  position within the current bit period, 0..P-1.
- `bit_cnt`  output  BIT_CNT_W  index of the current bit within the frame.
- `rx_sync`  output  1  synchronised `RX_IN`. The FSM uses it for start-edge detection.

## Operation
- **Synchroniser:** `RX_IN` passes through two flops to produce `rx_sync`. Every sample uses `rx_sync`, never `RX_IN`.
- **Effective prescale P:**
  - P is captured on the cycle `enable` rises (low to high).
  - Changes to `prescale` while `enable` is high are ignored.
  - If `prescale` is not 8, 16 or 32, P = 8.
- **Enable low:**
  - `edge_cnt` = 0, `bit_cnt` = 0, `sample_valid` = 0.
  - The three sample registers are held.
  - `sampled_bit` holds its last value.
- **Enable high:**
  - `edge_cnt` increments every cycle.
  - When `edge_cnt` reaches P-1, it wraps to 0 on the next cycle and `bit_cnt` increments.
  - `bit_cnt` saturates at 2^BIT_CNT_W - 1.
- **Sampling:** `rx_sync` is captured into s0, s1 and s2 on the cycles where `edge_cnt` = P/2-1, P/2 and P/2+1.
- **Decision:**
  - On the cycle where `edge_cnt` = P/2+2, `sampled_bit` <= majority(s0, s1, s2), i.e. (s0&s1)|(s0&s2)|(s1&s2).
  - `sample_valid` <= 1 on that same edge. It is registered and lasts exactly one cycle.
  - Exactly one decision is made per bit period.
- **Enable falls mid-bit:** counters clear on the next edge and no `sample_valid` is issued for the partial bit. Any decision already registered on that edge still completes.
- **Reset:** all state returns to reset values immediately, regardless of `enable`.

## Timing
- Reset values:
  - `sampled_bit` = 1, `rx_sync` = 1 (both synchroniser flops reset to 1).
  - `sample_valid` = 0, `edge_cnt` = 0, `bit_cnt` = 0.
  - s0, s1, s2 reset to 1.
- `RX_IN` to `rx_sync` latency: 2 cycles.
- `enable` rising at edge k:
  - First increment of `edge_cnt` occurs at edge k+1.
  - First `sample_valid` is high after edge k+1+P/2+2.
- Decision latency: `sample_valid` is high in the cycle after the third sample is taken, and lands P/2+3 cycles after a bit period begins (`edge_cnt` = 0).
- Consecutive `sample_valid` pulses are exactly P cycles apart while `enable` stays high.
- `enable` falling and a decision edge on the same cycle: that decision is issued, and counters clear on the following edge.
- `bit_cnt` and `edge_cnt` are registered outputs and change only on `CLK` edges.

## Structure
- **Package `uart_rx_pkg`:**
  - localparams `PRESCALE_8`, `PRESCALE_16`, `PRESCALE_32`, `PRESCALE_DEFAULT` (= 8).
  - `UART_IDLE` (= 1'b1).
  - The `majority3` function.
- **Sub-module `uart_rx_sync`:** generic 2-flop synchroniser with reset value parameter `RST_VAL`. It is instantiated once here, and the TX side reuses it as well.
- **Counters and sampling:** in the top level, one always block per counter. No FSM inside this block; frame sequencing belongs to the RX FSM.

## Test plan
- **Clean bits at P = 8:**
  - Stimulus: `enable` high, `RX_IN` drives a 4-bit pattern 0,1,0,1 held for 8 cycles per bit.
  - Required: four `sample_valid` pulses 8 cycles apart, `sampled_bit` = 0,1,0,1, `bit_cnt` = 0,1,2,3 at the pulses.
- **Glitch rejection at P = 16:**
  - Stimulus: `RX_IN` = 1 for the bit, with a one-cycle 0 landing on sample s1.
  - Required: `sampled_bit` = 1.
  - Stimulus: two-cycle 0 covering s1 and s2.
  - Required: `sampled_bit` = 0.
- **Full frame at P = 32:**
  - Stimulus: start 0, data 0xA5 LSB first, stop 1.
  - Required: 10 decisions 32 cycles apart, values 0,1,0,1,0,0,1,0,1,1, `bit_cnt` 0..9.
- **Illegal prescale:**
  - Stimulus: `prescale` = 12 at `enable` rise.
  - Required: `edge_cnt` wraps at 7 and pulses are 8 cycles apart.
  - Stimulus: change `prescale` to 16 mid-frame.
  - Required: no effect.
- **Enable drop mid-bit:**
  - Stimulus: drop `enable` at `edge_cnt` = 3, P = 8.
  - Required: no `sample_valid` for that bit, counters 0 next cycle, `sampled_bit` unchanged.
- **Reset mid-frame:**
  - Stimulus: assert `RST` at `edge_cnt` = P/2.
  - Required: all outputs at reset values immediately (asynchronous). After release with `enable` high, sampling restarts from `edge_cnt` = 0.
